// File: rtl/npn_tt_sweep_canon.sv
`default_nettype none
// ============================================================================
// Module      : npn_tt_sweep_canon
// Description : Reads a 4-input / 1-output combinational cell's truth table.
//               It steps x0..x3 through all 16 minterms, waits a
//               configurable settle time, and samples y0 once per minterm.
//               It then scans all 768 NPN transforms of the captured table
//               and reports the minimum table and the first index that
//               reaches it.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               start      - run request, accepted only in IDLE
//               busy       - run in progress (sweep or canon phase)
//               done       - one-cycle pulse, results valid
//               x0..x3     - drive the cell-under-test inputs
//               y0         - cell-under-test output
//               tt         - captured truth table, bit i = y0 at {x3..x0}=i
//               canon_tt   - NPN-canonical (minimum) truth table
//               canon_idx  - {perm[4:0], in_neg[3:0], out_neg} of first min
// Revision    : 1.0 - initial release
// ============================================================================
module npn_tt_sweep_canon #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CANON_EN      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    input  logic        y0,
    output logic [15:0] tt,
    output logic [15:0] canon_tt,
    output logic [9:0]  canon_idx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_CANON = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] C_SETTLE   = 4'(SETTLE_CYCLES);
    localparam logic [3:0] C_M_LAST   = 4'd15;
    localparam logic [9:0] C_IDX_LAST = 10'd767;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_settle;
    logic [3:0]  r_m;
    logic [3:0]  r_x;
    logic [9:0]  r_idx;
    logic [15:0] r_tt;
    logic [15:0] r_canon_tt;
    logic [9:0]  r_canon_idx;

    logic        w_sample;
    logic        w_sweep_last;
    logic        w_canon_last;
    logic [15:0] w_tt_sampled;
    logic [15:0] w_g;

    // p-th lexicographic permutation of (0,1,2,3), packed {p[3],p[2],p[1],p[0]}.
    // Only 0..23 are reachable because the index counter stops at 767.
    function automatic logic [7:0] f_perm(input logic [4:0] p);
        case (p)
            5'd0:    f_perm = {2'd3, 2'd2, 2'd1, 2'd0};
            5'd1:    f_perm = {2'd2, 2'd3, 2'd1, 2'd0};
            5'd2:    f_perm = {2'd3, 2'd1, 2'd2, 2'd0};
            5'd3:    f_perm = {2'd1, 2'd3, 2'd2, 2'd0};
            5'd4:    f_perm = {2'd2, 2'd1, 2'd3, 2'd0};
            5'd5:    f_perm = {2'd1, 2'd2, 2'd3, 2'd0};
            5'd6:    f_perm = {2'd3, 2'd2, 2'd0, 2'd1};
            5'd7:    f_perm = {2'd2, 2'd3, 2'd0, 2'd1};
            5'd8:    f_perm = {2'd3, 2'd0, 2'd2, 2'd1};
            5'd9:    f_perm = {2'd0, 2'd3, 2'd2, 2'd1};
            5'd10:   f_perm = {2'd2, 2'd0, 2'd3, 2'd1};
            5'd11:   f_perm = {2'd0, 2'd2, 2'd3, 2'd1};
            5'd12:   f_perm = {2'd3, 2'd1, 2'd0, 2'd2};
            5'd13:   f_perm = {2'd1, 2'd3, 2'd0, 2'd2};
            5'd14:   f_perm = {2'd3, 2'd0, 2'd1, 2'd2};
            5'd15:   f_perm = {2'd0, 2'd3, 2'd1, 2'd2};
            5'd16:   f_perm = {2'd1, 2'd0, 2'd3, 2'd2};
            5'd17:   f_perm = {2'd0, 2'd1, 2'd3, 2'd2};
            5'd18:   f_perm = {2'd2, 2'd1, 2'd0, 2'd3};
            5'd19:   f_perm = {2'd1, 2'd2, 2'd0, 2'd3};
            5'd20:   f_perm = {2'd2, 2'd0, 2'd1, 2'd3};
            5'd21:   f_perm = {2'd0, 2'd2, 2'd1, 2'd3};
            5'd22:   f_perm = {2'd1, 2'd0, 2'd2, 2'd3};
            5'd23:   f_perm = {2'd0, 2'd1, 2'd2, 2'd3};
            default: f_perm = {2'd3, 2'd2, 2'd1, 2'd0};
        endcase
    endfunction

    // g[i] = out_neg ^ tbl[j], with j[k] = i[perm[k]] ^ in_neg[k].
    function automatic logic [15:0] f_transform(
        input logic [15:0] tbl,
        input logic [7:0]  perm,
        input logic [3:0]  in_neg,
        input logic        out_neg
    );
        logic [15:0] g;
        logic [3:0]  i_v;
        logic [3:0]  j_v;
        g = '0;
        for (int i = 0; i < 16; i++) begin
            i_v = 4'(i);
            for (int k = 0; k < 4; k++) begin
                j_v[k] = i_v[perm[2*k +: 2]] ^ in_neg[k];
            end
            g[i] = out_neg ^ tbl[j_v];
        end
        return g;
    endfunction

    // y0 is looked at only on the last settle cycle of each minterm.
    assign w_sample     = (r_state == S_SWEEP) && (r_settle == C_SETTLE);
    assign w_sweep_last = w_sample && (r_m == C_M_LAST);
    assign w_canon_last = (r_state == S_CANON) && (r_idx == C_IDX_LAST);

    // Table including the bit sampled this cycle; needed so the no-canon
    // path can copy a complete table on the final sample.
    always_comb begin
        w_tt_sampled      = r_tt;
        w_tt_sampled[r_m] = y0;
    end

    if (CANON_EN != 0) begin : g_canon
        assign w_g = f_transform(r_tt, f_perm(r_idx[9:5]), r_idx[4:1], r_idx[0]);
    end else begin : g_no_canon
        assign w_g = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (w_sweep_last) begin
                    w_state_next = (CANON_EN != 0) ? S_CANON : S_DONE;
                end
            end
            S_CANON: begin
                if (w_canon_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle    <= '0;
            r_m         <= '0;
            r_x         <= '0;
            r_idx       <= '0;
            r_tt        <= '0;
            r_canon_tt  <= '0;
            r_canon_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tt     <= '0;
                        r_m      <= '0;
                        r_settle <= '0;
                        r_x      <= '0;
                    end
                end
                S_SWEEP: begin
                    if (w_sample) begin
                        r_tt     <= w_tt_sampled;
                        r_settle <= '0;
                        if (r_m == C_M_LAST) begin
                            r_x   <= '0;
                            r_m   <= '0;
                            r_idx <= '0;
                            if (CANON_EN == 0) begin
                                r_canon_tt  <= w_tt_sampled;
                                r_canon_idx <= '0;
                            end
                        end else begin
                            r_m <= r_m + 4'd1;
                            r_x <= r_m + 4'd1;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_CANON: begin
                    // Strict less-than keeps the earliest index on ties.
                    if ((r_idx == 10'd0) || (w_g < r_canon_tt)) begin
                        r_canon_tt  <= w_g;
                        r_canon_idx <= r_idx;
                    end
                    r_idx <= r_idx + 10'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state == S_SWEEP) || (r_state == S_CANON);
    assign done      = (r_state == S_DONE);
    assign x0        = r_x[0];
    assign x1        = r_x[1];
    assign x2        = r_x[2];
    assign x3        = r_x[3];
    assign tt        = r_tt;
    assign canon_tt  = r_canon_tt;
    assign canon_idx = r_canon_idx;

endmodule
`default_nettype wire

// File: tb/tb_npn_tt_sweep_canon.sv
`default_nettype none
// ============================================================================
// Module      : tb_npn_tt_sweep_canon
// Description : Directed self-checking bench for npn_tt_sweep_canon. One
//               default instance plus two no-canon instances (settle 0 and
//               settle 1) that read a cell with one register of delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npn_tt_sweep_canon;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        start_aux;

    logic        busy, done, x0, x1, x2, x3, y0;
    logic [15:0] tt, canon_tt;
    logic [9:0]  canon_idx;

    logic        busy_a, done_a, xa0, xa1, xa2, xa3, ya;
    logic [15:0] tt_a, ctt_a;
    logic [9:0]  cidx_a;

    logic        busy_b, done_b, xb0, xb1, xb2, xb3, yb;
    logic [15:0] tt_b, ctt_b;
    logic [9:0]  cidx_b;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    int age      = 0;
    logic [3:0] last_x = 4'd0;
    logic [3:0] xlog [0:63];

    npn_tt_sweep_canon dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0),
        .tt(tt), .canon_tt(canon_tt), .canon_idx(canon_idx)
    );

    npn_tt_sweep_canon #(.SETTLE_CYCLES(0), .CANON_EN(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_aux), .busy(busy_a), .done(done_a),
        .x0(xa0), .x1(xa1), .x2(xa2), .x3(xa3), .y0(ya),
        .tt(tt_a), .canon_tt(ctt_a), .canon_idx(cidx_a)
    );

    npn_tt_sweep_canon #(.SETTLE_CYCLES(1), .CANON_EN(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_aux), .busy(busy_b), .done(done_b),
        .x0(xb0), .x1(xb1), .x2(xb2), .x3(xb3), .y0(yb),
        .tt(tt_b), .canon_tt(ctt_b), .canon_idx(cidx_b)
    );

    // Cell under test for T4; truth table 0x1796.
    function automatic logic cell_f(input logic [3:0] x);
        return (x[2] & ((~x[0] & ~x[1]) | (~x[3] & x[0] & x[1]))) |
               (~x[2] & ~(x[0] & x[1]) & ~(~x[3] & ~x[0] & ~x[1]));
    endfunction

    // Cycles the main instance's inputs have held their current value.
    always @(negedge clk) begin
        if ({x3, x2, x1, x0} != last_x) age <= 0;
        else if (age < 15)               age <= age + 1;
        last_x <= {x3, x2, x1, x0};
    end

    // Mode 3 gives the wrong answer until the inputs have been stable for
    // two full cycles, so only the designated sample cycle sees the truth.
    always_comb begin
        case (mode)
            0:       y0 = 1'b0;
            1:       y0 = 1'b1;
            2:       y0 = x0;
            default: y0 = (age >= 2) ? cell_f({x3, x2, x1, x0}) : ~cell_f({x3, x2, x1, x0});
        endcase
    end

    // One-register-delayed cells for the no-canon instances.
    always @(posedge clk) begin
        ya <= cell_f({xa3, xa2, xa1, xa0});
        yb <= cell_f({xb3, xb2, xb1, xb0});
    end

    // Reference NPN canonicalisation, enumerating permutations by nested loops.
    function automatic void model_canon(input logic [15:0] t, output logic [15:0] best,
                                        output int best_idx);
        int p;
        int pm [4];
        int j;
        int idx;
        logic [15:0] g;
        p = 0;
        best = '0;
        best_idx = 0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 4; c++) begin
                    if (a != b && a != c && b != c) begin
                        pm[0] = a; pm[1] = b; pm[2] = c; pm[3] = 6 - a - b - c;
                        for (int inn = 0; inn < 16; inn++) begin
                            for (int on = 0; on < 2; on++) begin
                                for (int i = 0; i < 16; i++) begin
                                    j = 0;
                                    for (int k = 0; k < 4; k++) begin
                                        if ((((i >> pm[k]) & 1) ^ ((inn >> k) & 1)) != 0)
                                            j = j | (1 << k);
                                    end
                                    g[i] = 1'(on) ^ t[j];
                                end
                                idx = p * 32 + inn * 2 + on;
                                if (idx == 0 || g < best) begin
                                    best = g;
                                    best_idx = idx;
                                end
                            end
                        end
                        p++;
                    end
                end
            end
        end
    endfunction

    // Runs the main instance once; returns cycles from accepted start to done
    // (-1 on timeout), busy in cycle 1 and busy in the done cycle.
    task automatic run_main(output int lat, output logic busy1, output logic busy_dn);
        lat = -1;
        busy1 = 1'b0;
        busy_dn = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy1 = busy;
        for (int n = 1; n < 3000; n++) begin
            if (n < 64) xlog[n] = {x3, x2, x1, x0};
            if (done) begin
                lat = n;
                busy_dn = busy;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_aux = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if ({x3, x2, x1, x0} !== 4'h0) begin failures++; $display("FAIL reset_x got %h exp 0", {x3, x2, x1, x0}); end
        checks++; if (tt !== 16'h0) begin failures++; $display("FAIL reset_tt got %h exp 0000", tt); end
        checks++; if (canon_tt !== 16'h0) begin failures++; $display("FAIL reset_canon_tt got %h exp 0000", canon_tt); end
        checks++; if (canon_idx !== 10'd0) begin failures++; $display("FAIL reset_canon_idx got %0d exp 0", canon_idx); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_const0();
        int lat; logic b1, bd;
        mode = 0;
        run_main(lat, b1, bd);
        checks++; if (lat !== 817) begin failures++; $display("FAIL t1_latency got %0d exp 817", lat); end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL t1_busy_cycle1 got %b exp 1", b1); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL t1_busy_done got %b exp 0", bd); end
        checks++; if (tt !== 16'h0000) begin failures++; $display("FAIL t1_tt got %h exp 0000", tt); end
        checks++; if (canon_tt !== 16'h0000) begin failures++; $display("FAIL t1_canon_tt got %h exp 0000", canon_tt); end
        checks++; if (canon_idx !== 10'd0) begin failures++; $display("FAIL t1_canon_idx got %0d exp 0", canon_idx); end
    endtask

    task automatic test_const1();
        int lat; logic b1, bd;
        mode = 1;
        run_main(lat, b1, bd);
        checks++; if (lat !== 817) begin failures++; $display("FAIL t2_latency got %0d exp 817", lat); end
        checks++; if (tt !== 16'hFFFF) begin failures++; $display("FAIL t2_tt got %h exp ffff", tt); end
        checks++; if (canon_tt !== 16'h0000) begin failures++; $display("FAIL t2_canon_tt got %h exp 0000", canon_tt); end
        checks++; if (canon_idx !== 10'd1) begin failures++; $display("FAIL t2_canon_idx got %0d exp 1", canon_idx); end
    endtask

    task automatic test_x0();
        int lat; logic b1, bd;
        mode = 2;
        run_main(lat, b1, bd);
        checks++; if (tt !== 16'hAAAA) begin failures++; $display("FAIL t3_tt got %h exp aaaa", tt); end
        checks++; if (canon_tt !== 16'h00FF) begin failures++; $display("FAIL t3_canon_tt got %h exp 00ff", canon_tt); end
        // perm 18 = (3,0,1,2), in_neg 0, out_neg 1: g = ~x3.
        checks++; if (canon_idx !== 10'd577) begin failures++; $display("FAIL t3_canon_idx got %0d exp 577", canon_idx); end
        checks++; if (xlog[3] !== 4'd0) begin failures++; $display("FAIL t3_x_cyc3 got %0d exp 0", xlog[3]); end
        checks++; if (xlog[4] !== 4'd1) begin failures++; $display("FAIL t3_x_cyc4 got %0d exp 1", xlog[4]); end
        checks++; if (xlog[7] !== 4'd2) begin failures++; $display("FAIL t3_x_cyc7 got %0d exp 2", xlog[7]); end
        checks++; if (xlog[48] !== 4'd15) begin failures++; $display("FAIL t3_x_cyc48 got %0d exp 15", xlog[48]); end
        checks++; if (xlog[49] !== 4'd0) begin failures++; $display("FAIL t3_x_cyc49 got %0d exp 0", xlog[49]); end
    endtask

    task automatic test_formula();
        int lat; logic b1, bd;
        logic [15:0] m_tt; int m_idx;
        mode = 3;
        model_canon(16'h1796, m_tt, m_idx);
        run_main(lat, b1, bd);
        checks++; if (lat !== 817) begin failures++; $display("FAIL t4_latency got %0d exp 817", lat); end
        checks++; if (tt !== 16'h1796) begin failures++; $display("FAIL t4_tt got %h exp 1796", tt); end
        checks++; if (canon_tt !== m_tt) begin failures++; $display("FAIL t4_canon_tt got %h exp %h", canon_tt, m_tt); end
        checks++; if (canon_idx !== 10'(m_idx)) begin failures++; $display("FAIL t4_canon_idx got %0d exp %0d", canon_idx, m_idx); end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL t4_done_pulse got %b exp 0", done); end
        checks++; if (tt !== 16'h1796) begin failures++; $display("FAIL t4_tt_hold got %h exp 1796", tt); end
        checks++; if (canon_tt !== m_tt) begin failures++; $display("FAIL t4_canon_hold got %h exp %h", canon_tt, m_tt); end
    endtask

    task automatic test_settle();
        int lat_a; int lat_b;
        lat_a = -1; lat_b = -1;
        @(negedge clk); start_aux = 1'b1;
        @(negedge clk); start_aux = 1'b0;
        for (int n = 1; n < 100; n++) begin
            if (done_a && lat_a < 0) lat_a = n;
            if (done_b && lat_b < 0) lat_b = n;
            @(negedge clk);
        end
        checks++; if (lat_a !== 17) begin failures++; $display("FAIL t5_s0_latency got %0d exp 17", lat_a); end
        checks++; if (lat_b !== 33) begin failures++; $display("FAIL t5_s1_latency got %0d exp 33", lat_b); end
        checks++; if (tt_a !== 16'h2F2C) begin failures++; $display("FAIL t5_s0_tt got %h exp 2f2c", tt_a); end
        checks++; if (tt_b !== 16'h1796) begin failures++; $display("FAIL t5_s1_tt got %h exp 1796", tt_b); end
        checks++; if (ctt_a !== 16'h2F2C) begin failures++; $display("FAIL t5_s0_canon_tt got %h exp 2f2c", ctt_a); end
        checks++; if (ctt_b !== 16'h1796) begin failures++; $display("FAIL t5_s1_canon_tt got %h exp 1796", ctt_b); end
        checks++; if (cidx_b !== 10'd0) begin failures++; $display("FAIL t5_s1_canon_idx got %0d exp 0", cidx_b); end
    endtask

    task automatic test_back_to_back();
        int lat; int ndone;
        lat = -1; ndone = 0;
        mode = 2;
        @(negedge clk); start = 1'b1;
        for (int n = 1; n < 1200; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            // start stays high through the done cycle, then drops in IDLE.
            if (lat >= 0 && n == lat + 1) start = 1'b0;
        end
        start = 1'b0;
        checks++; if (lat !== 817) begin failures++; $display("FAIL b2b_latency got %0d exp 817", lat); end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL b2b_done_count got %0d exp 1", ndone); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
        checks++; if (canon_idx !== 10'd577) begin failures++; $display("FAIL b2b_canon_idx got %0d exp 577", canon_idx); end
    endtask

    task automatic test_reset_mid();
        int lat; logic b1, bd;
        logic [15:0] m_tt; int m_idx;
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (99) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t6_busy_before got %b exp 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL t6_done got %b exp 0", done); end
        checks++; if (tt !== 16'h0) begin failures++; $display("FAIL t6_tt got %h exp 0000", tt); end
        checks++; if (canon_tt !== 16'h0) begin failures++; $display("FAIL t6_canon_tt got %h exp 0000", canon_tt); end
        checks++; if (canon_idx !== 10'd0) begin failures++; $display("FAIL t6_canon_idx got %0d exp 0", canon_idx); end
        mode = 3;
        model_canon(16'h1796, m_tt, m_idx);
        run_main(lat, b1, bd);
        checks++; if (lat !== 817) begin failures++; $display("FAIL t6_rerun_latency got %0d exp 817", lat); end
        checks++; if (tt !== 16'h1796) begin failures++; $display("FAIL t6_rerun_tt got %h exp 1796", tt); end
        checks++; if (canon_tt !== m_tt) begin failures++; $display("FAIL t6_rerun_canon got %h exp %h", canon_tt, m_tt); end
    endtask

    initial begin
        test_reset();
        test_const0();
        test_const1();
        test_x0();
        test_formula();
        test_settle();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
